// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - IF/DM arbiter for one single-ported unified memory
// Grants one transaction at a time; watchdog aborts hung cycles and sets a sticky bus_err.
module mem_port_arbiter #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int TIMEOUT    = 16,
  parameter int STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_done,
  output logic [DW-1:0] if_rdata,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic          dm_done,
  output logic [DW-1:0] dm_rdata,
  output logic          stall_if,
  output logic          stall_dm,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_ack,
  input  logic [DW-1:0] mem_rdata,
  output logic          bus_err
);

  localparam int TW = $clog2(TIMEOUT);
  localparam int SW = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_DM} state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [SW-1:0] starve_q, starve_d;
  logic          mem_req_q, mem_req_d;
  logic          mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic          if_done_q, if_done_d;
  logic          dm_done_q, dm_done_d;
  logic [DW-1:0] if_rdata_q, if_rdata_d;
  logic [DW-1:0] dm_rdata_q, dm_rdata_d;
  logic          bus_err_q, bus_err_d;

  logic elig_if, elig_dm, force_if, grant_if, grant_dm;
  logic busy, timeout, finish;

  // Masking with done keeps a requester from being re-granted in its own done cycle.
  assign elig_if  = if_req & ~if_done_q;
  assign elig_dm  = dm_req & ~dm_done_q;
  assign force_if = (starve_q == SW'(STARVE_MAX)) & elig_if;
  assign grant_dm = (state_q == IDLE) & elig_dm & ~force_if;
  assign grant_if = (state_q == IDLE) & elig_if & ~grant_dm;
  assign busy     = (state_q != IDLE);
  assign timeout  = busy & ~mem_ack & (tmo_q == TW'(TIMEOUT - 1));
  assign finish   = busy & (mem_ack | timeout);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      tmo_q       <= '0;
      starve_q    <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_done_q   <= 1'b0;
      dm_done_q   <= 1'b0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      bus_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      tmo_q       <= tmo_d;
      starve_q    <= starve_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_done_q   <= if_done_d;
      dm_done_q   <= dm_done_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
      bus_err_q   <= bus_err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (grant_dm)      state_d = BUSY_DM;
        else if (grant_if) state_d = BUSY_IF;
      end
      BUSY_IF, BUSY_DM: begin
        if (finish) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    tmo_d       = tmo_q;
    starve_d    = starve_q;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    if_done_d   = (state_q == BUSY_IF) & finish;
    dm_done_d   = (state_q == BUSY_DM) & finish;
    bus_err_d   = bus_err_q | timeout;

    if (grant_dm) begin
      mem_req_d   = 1'b1;
      mem_we_d    = dm_we;
      mem_addr_d  = dm_addr;
      mem_wdata_d = dm_wdata;
      tmo_d       = '0;
      if (!elig_if)                            starve_d = '0;
      else if (starve_q != SW'(STARVE_MAX))    starve_d = starve_q + 1'b1;
    end else if (grant_if) begin
      mem_req_d  = 1'b1;
      mem_we_d   = 1'b0;
      mem_addr_d = if_addr;
      tmo_d      = '0;
      starve_d   = '0;
    end else if (finish) begin
      mem_req_d = 1'b0;
    end else if (busy) begin
      tmo_d = tmo_q + 1'b1;
    end

    // A store or an aborted cycle returns zero data.
    if (state_q == BUSY_IF && finish)
      if_rdata_d = mem_ack ? mem_rdata : '0;
    if (state_q == BUSY_DM && finish)
      dm_rdata_d = (mem_ack && !mem_we_q) ? mem_rdata : '0;
  end

  always_comb begin
    mem_req   = mem_req_q;
    mem_we    = mem_we_q;
    mem_addr  = mem_addr_q;
    mem_wdata = mem_wdata_q;
    if_done   = if_done_q;
    dm_done   = dm_done_q;
    if_rdata  = if_rdata_q;
    dm_rdata  = dm_rdata_q;
    bus_err   = bus_err_q;
    stall_if  = if_req & ~if_done_q;
    stall_dm  = dm_req & ~dm_done_q;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed vector bench for mem_port_arbiter
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        if_done;
  logic [31:0] if_rdata;
  logic        dm_req = 1'b0;
  logic        dm_we = 1'b0;
  logic [31:0] dm_addr = '0;
  logic [31:0] dm_wdata = '0;
  logic        dm_done;
  logic [31:0] dm_rdata;
  logic        stall_if, stall_dm;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        bus_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.AW(32), .DW(32), .TIMEOUT(16), .STARVE_MAX(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_done(dm_done), .dm_rdata(dm_rdata),
    .stall_if(stall_if), .stall_dm(stall_dm),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .bus_err(bus_err)
  );

  typedef struct {
    logic        if_req;
    logic [31:0] if_addr;
    logic        dm_req, dm_we;
    logic [31:0] dm_addr, dm_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        e_if_done;
    logic [31:0] e_if_rdata;
    logic        e_dm_done;
    logic [31:0] e_dm_rdata;
    logic        e_mem_req, e_mem_we;
    logic [31:0] e_mem_addr, e_mem_wdata;
    logic        e_stall_if, e_stall_dm, e_bus_err;
  } vec_t;

  vec_t vecs[17];

  function automatic vec_t mk(
    input logic ir, input logic [31:0] ia, input logic dr, input logic dw,
    input logic [31:0] da, input logic [31:0] dd, input logic ak, input logic [31:0] rd,
    input logic eid, input logic [31:0] eird, input logic edd, input logic [31:0] edrd,
    input logic emr, input logic emw, input logic [31:0] ema, input logic [31:0] emd,
    input logic esi, input logic esd, input logic ebe);
    vec_t v;
    v.if_req = ir; v.if_addr = ia; v.dm_req = dr; v.dm_we = dw;
    v.dm_addr = da; v.dm_wdata = dd; v.mem_ack = ak; v.mem_rdata = rd;
    v.e_if_done = eid; v.e_if_rdata = eird; v.e_dm_done = edd; v.e_dm_rdata = edrd;
    v.e_mem_req = emr; v.e_mem_we = emw; v.e_mem_addr = ema; v.e_mem_wdata = emd;
    v.e_stall_if = esi; v.e_stall_dm = esd; v.e_bus_err = ebe;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    int busy_cnt;
    int done_at;
    int got;

    // single fetch (0-3), DM store vs IF (4-9), load with 3 wait states (10-16)
    vecs[0]  = mk(1, 32'h100, 0, 0, 0, 0, 0, 0,                      0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    vecs[1]  = mk(1, 32'h100, 0, 0, 0, 0, 1, 32'h00500093,           0, 0, 0, 0, 1, 0, 32'h100, 0, 1, 0, 0);
    vecs[2]  = mk(1, 32'h100, 0, 0, 0, 0, 0, 0,                      1, 32'h00500093, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs[3]  = mk(0, 0, 0, 0, 0, 0, 0, 0,                            0, 32'h00500093, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs[4]  = mk(1, 32'h104, 1, 1, 32'h200, 32'hDEADBEEF, 0, 0,     0, 32'h00500093, 0, 0, 0, 0, 0, 0, 1, 1, 0);
    vecs[5]  = mk(1, 32'h104, 1, 1, 32'h200, 32'hDEADBEEF, 1, 32'h12345678,
                                                                     0, 32'h00500093, 0, 0, 1, 1, 32'h200, 32'hDEADBEEF, 1, 1, 0);
    vecs[6]  = mk(1, 32'h104, 1, 1, 32'h200, 32'hDEADBEEF, 0, 0,     0, 32'h00500093, 1, 0, 0, 0, 0, 0, 1, 0, 0);
    vecs[7]  = mk(1, 32'h104, 0, 0, 0, 0, 1, 32'hA0A0A0A0,           0, 32'h00500093, 0, 0, 1, 0, 32'h104, 32'hDEADBEEF, 1, 0, 0);
    vecs[8]  = mk(1, 32'h104, 0, 0, 0, 0, 0, 0,                      1, 32'hA0A0A0A0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs[9]  = mk(0, 0, 0, 0, 0, 0, 0, 0,                            0, 32'hA0A0A0A0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs[10] = mk(0, 0, 1, 0, 32'h300, 0, 0, 0,                      0, 32'hA0A0A0A0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    vecs[11] = mk(0, 0, 1, 0, 32'h300, 0, 0, 0,                      0, 32'hA0A0A0A0, 0, 0, 1, 0, 32'h300, 0, 0, 1, 0);
    vecs[12] = mk(0, 0, 1, 0, 32'h300, 0, 0, 0,                      0, 32'hA0A0A0A0, 0, 0, 1, 0, 32'h300, 0, 0, 1, 0);
    vecs[13] = mk(0, 0, 1, 0, 32'h300, 0, 0, 0,                      0, 32'hA0A0A0A0, 0, 0, 1, 0, 32'h300, 0, 0, 1, 0);
    vecs[14] = mk(0, 0, 1, 0, 32'h300, 0, 1, 32'hCAFEF00D,           0, 32'hA0A0A0A0, 0, 0, 1, 0, 32'h300, 0, 0, 1, 0);
    vecs[15] = mk(0, 0, 1, 0, 32'h300, 0, 0, 0,                      0, 32'hA0A0A0A0, 1, 32'hCAFEF00D, 0, 0, 0, 0, 0, 0, 0);
    vecs[16] = mk(0, 0, 0, 0, 0, 0, 0, 0,                            0, 32'hA0A0A0A0, 0, 32'hCAFEF00D, 0, 0, 0, 0, 0, 0, 0);

    // reset
    repeat (3) tick();
    #2;
    chk("rst_mem_req", {31'b0, mem_req}, 0);
    chk("rst_mem_we", {31'b0, mem_we}, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_dones", {30'b0, if_done, dm_done}, 0);
    chk("rst_if_rdata", if_rdata, 0);
    chk("rst_dm_rdata", dm_rdata, 0);
    chk("rst_bus_err", {31'b0, bus_err}, 0);
    tick();
    reset_n = 1'b1;
    tick();
    #2;
    chk("post_rst_mem_req", {31'b0, mem_req}, 0);

    for (int i = 0; i < 17; i++) begin
      tick();
      if_req = vecs[i].if_req; if_addr = vecs[i].if_addr;
      dm_req = vecs[i].dm_req; dm_we = vecs[i].dm_we;
      dm_addr = vecs[i].dm_addr; dm_wdata = vecs[i].dm_wdata;
      mem_ack = vecs[i].mem_ack; mem_rdata = vecs[i].mem_rdata;
      #2;
      chk($sformatf("v%0d_if_done", i), {31'b0, if_done}, {31'b0, vecs[i].e_if_done});
      chk($sformatf("v%0d_if_rdata", i), if_rdata, vecs[i].e_if_rdata);
      chk($sformatf("v%0d_dm_done", i), {31'b0, dm_done}, {31'b0, vecs[i].e_dm_done});
      chk($sformatf("v%0d_dm_rdata", i), dm_rdata, vecs[i].e_dm_rdata);
      chk($sformatf("v%0d_mem_req", i), {31'b0, mem_req}, {31'b0, vecs[i].e_mem_req});
      chk($sformatf("v%0d_stall_if", i), {31'b0, stall_if}, {31'b0, vecs[i].e_stall_if});
      chk($sformatf("v%0d_stall_dm", i), {31'b0, stall_dm}, {31'b0, vecs[i].e_stall_dm});
      chk($sformatf("v%0d_bus_err", i), {31'b0, bus_err}, {31'b0, vecs[i].e_bus_err});
      if (vecs[i].e_mem_req) begin
        chk($sformatf("v%0d_mem_we", i), {31'b0, mem_we}, {31'b0, vecs[i].e_mem_we});
        chk($sformatf("v%0d_mem_addr", i), mem_addr, vecs[i].e_mem_addr);
        chk($sformatf("v%0d_mem_wdata", i), mem_wdata, vecs[i].e_mem_wdata);
      end
    end

    // timeout: load with no ack -> 16 busy cycles, done on the 17th cycle after the req
    tick();
    dm_req = 1; dm_we = 0; dm_addr = 32'h400; dm_wdata = 0; mem_ack = 0;
    busy_cnt = 0; done_at = -1;
    for (int k = 1; k <= 40 && done_at < 0; k++) begin
      tick();
      #2;
      if (mem_req) busy_cnt++;
      if (dm_done) begin
        done_at = k;
        chk("tmo_dm_rdata", dm_rdata, 0);
        chk("tmo_bus_err", {31'b0, bus_err}, 1);
        chk("tmo_stall_dm", {31'b0, stall_dm}, 0);
      end
    end
    chk("tmo_done_at", done_at, 17);
    chk("tmo_busy_cycles", busy_cnt, 16);
    tick();
    dm_req = 0;

    // good fetch afterwards: bus_err stays set
    tick();
    if_req = 1; if_addr = 32'h180; mem_ack = 1; mem_rdata = 32'h13572468;
    got = 0;
    for (int k = 0; k < 20 && got == 0; k++) begin
      tick();
      #2;
      if (if_done) got = 1;
    end
    chk("sticky_fetch_done", got, 1);
    chk("sticky_if_rdata", if_rdata, 32'h13572468);
    chk("sticky_bus_err", {31'b0, bus_err}, 1);
    tick();
    if_req = 0; mem_ack = 0;

    // starvation: four DM grants with IF pending, then IF is forced ahead of DM
    for (int i = 0; i < 4; i++) begin
      tick();
      if_req = 1; if_addr = 32'h600;
      dm_req = 1; dm_we = 0; dm_addr = 32'h500 + 32'(4 * i); mem_ack = 0;
      tick();
      if_req = 0; mem_ack = 1; mem_rdata = 32'(i);
      #2;
      chk($sformatf("starve%0d_mem_addr", i), mem_addr, 32'h500 + 32'(4 * i));
      chk($sformatf("starve%0d_mem_req", i), {31'b0, mem_req}, 1);
      tick();
      mem_ack = 0;
      #2;
      chk($sformatf("starve%0d_dm_done", i), {31'b0, dm_done}, 1);
    end
    tick();
    if_req = 1; if_addr = 32'h600;
    dm_req = 1; dm_addr = 32'h510; mem_ack = 0;
    tick();
    mem_ack = 1; mem_rdata = 32'h0BADF00D;
    #2;
    chk("forced_if_mem_addr", mem_addr, 32'h600);
    chk("forced_if_mem_we", {31'b0, mem_we}, 0);
    tick();
    mem_ack = 0;
    #2;
    chk("forced_if_done", {31'b0, if_done}, 1);
    chk("forced_if_rdata", if_rdata, 32'h0BADF00D);
    tick();
    if_req = 0; mem_ack = 1; mem_rdata = 32'h55AA55AA;
    #2;
    chk("after_force_dm_addr", mem_addr, 32'h510);
    tick();
    mem_ack = 0;
    #2;
    chk("after_force_dm_done", {31'b0, dm_done}, 1);
    chk("after_force_dm_rdata", dm_rdata, 32'h55AA55AA);
    tick();
    dm_req = 0;

    // reset during BUSY_DM: immediate idle and no done pulse
    tick();
    dm_req = 1; dm_we = 0; dm_addr = 32'h700; mem_ack = 0;
    tick();
    tick();
    #2;
    chk("midrst_busy", {31'b0, mem_req}, 1);
    tick();
    reset_n = 0;
    #2;
    chk("midrst_mem_req", {31'b0, mem_req}, 0);
    chk("midrst_mem_addr", mem_addr, 0);
    chk("midrst_bus_err", {31'b0, bus_err}, 0);
    chk("midrst_dm_rdata", dm_rdata, 0);
    tick();
    tick();
    reset_n = 1; dm_req = 0;
    got = 0;
    for (int k = 0; k < 5; k++) begin
      tick();
      #2;
      if (dm_done || mem_req) got = 1;
    end
    chk("midrst_no_done", got, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
